// File: rtl/mmu_page_responder.sv
// mmu_page_responder
// Memory-side responder for the CPU MMU request interface. Keeps the page
// chain / logical page tables, translates logical addresses to physical RAM
// addresses, allocates pages on demand and builds / tears down segment chains.
// One request is in flight at a time; the response is held until consumed.
module mmu_page_responder #(
    parameter int PAGE_SIZE = 5,
    parameter int PAGES     = 204,
    parameter int ADDR_W    = 10,
    parameter int PG_W      = 8
) (
    input  logic              clka,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_cmd,
    input  logic [PG_W-1:0]   req_seg,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [ADDR_W-1:0] resp_addr,
    output logic [PG_W-1:0]   resp_page,
    output logic              resp_alloc,
    output logic              resp_error
);

    localparam logic [1:0]      CMD_TRANSLATE = 2'd0;
    localparam logic [1:0]      CMD_NEW_SEG   = 2'd1;
    localparam logic [1:0]      CMD_FREE_SEG  = 2'd2;
    localparam logic [PG_W-1:0] LAST_PG       = PG_W'(PAGES - 1);
    // scan gives up after PAGES-1 tests (page 0 is never a candidate)
    localparam logic [PG_W-1:0] SCAN_LAST     = PG_W'(PAGES - 2);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_WALK, S_SCAN, S_FREE, S_RESP
    } state_t;

    // page tables (cleared by the INIT sweep, not by reset)
    logic              used_mem  [PAGES];
    logic [PG_W-1:0]   chain_mem [PAGES];
    logic [ADDR_W-1:0] lpage_mem [PAGES];

    // control state
    state_t            state_q, state_d;
    logic [PG_W-1:0]   cnt_q, cnt_d;
    logic [PG_W-1:0]   ptr_q, ptr_d;
    logic              cache_vld_q, cache_vld_d;
    logic [ADDR_W-1:0] resp_addr_q, resp_addr_d;
    logic [PG_W-1:0]   resp_page_q, resp_page_d;
    logic              resp_alloc_q, resp_alloc_d;
    logic              resp_error_q, resp_error_d;

    // per-request working data and cache payload
    logic              is_tr_q, is_tr_d;
    logic [PG_W-1:0]   seg_q, seg_d;
    logic [PG_W-1:0]   cur_q, cur_d;
    logic [ADDR_W-1:0] lp_q, lp_d;
    logic [ADDR_W-1:0] off_q, off_d;
    logic [PG_W-1:0]   cache_seg_q, cache_seg_d;
    logic [ADDR_W-1:0] cache_lp_q, cache_lp_d;
    logic [PG_W-1:0]   cache_pg_q, cache_pg_d;

    // table write ports: one whole-entry write plus one chain link write
    logic              ent_we;
    logic [PG_W-1:0]   ent_idx;
    logic              ent_used;
    logic              ent_lp_we;
    logic [ADDR_W-1:0] ent_lp;
    logic              link_we;
    logic [PG_W-1:0]   link_idx;
    logic [PG_W-1:0]   link_val;

    logic [ADDR_W-1:0] req_lp;
    logic [ADDR_W-1:0] req_off;
    logic              seg_ok;
    logic              cache_hit;
    logic [PG_W-1:0]   nxt_pg;

    function automatic logic [PG_W-1:0] ptr_inc(input logic [PG_W-1:0] p);
        if (p >= LAST_PG) return PG_W'(1);
        return p + PG_W'(1);
    endfunction

    function automatic logic [ADDR_W-1:0] phys_addr(input logic [PG_W-1:0]   pg,
                                                    input logic [ADDR_W-1:0] off);
        return ADDR_W'(pg) * ADDR_W'(PAGE_SIZE) + off;
    endfunction

    assign req_lp    = req_addr / ADDR_W'(PAGE_SIZE);
    assign req_off   = req_addr % ADDR_W'(PAGE_SIZE);
    assign seg_ok    = (req_seg != '0) && (req_seg <= LAST_PG) && used_mem[req_seg];
    assign cache_hit = cache_vld_q && (cache_seg_q == req_seg) && (cache_lp_q == req_lp);
    assign nxt_pg    = chain_mem[cur_q];

    // control registers, cleared asynchronously
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state_q      <= S_INIT;
            cnt_q        <= '0;
            ptr_q        <= PG_W'(1);
            cache_vld_q  <= 1'b0;
            resp_addr_q  <= '0;
            resp_page_q  <= '0;
            resp_alloc_q <= 1'b0;
            resp_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            cache_vld_q  <= cache_vld_d;
            resp_addr_q  <= resp_addr_d;
            resp_page_q  <= resp_page_d;
            resp_alloc_q <= resp_alloc_d;
            resp_error_q <= resp_error_d;
        end
    end

    // working data registers; only meaningful once loaded by a request
    always_ff @(posedge clka) begin
        is_tr_q     <= is_tr_d;
        seg_q       <= seg_d;
        cur_q       <= cur_d;
        lp_q        <= lp_d;
        off_q       <= off_d;
        cache_seg_q <= cache_seg_d;
        cache_lp_q  <= cache_lp_d;
        cache_pg_q  <= cache_pg_d;
    end

    // table updates; entry and link indices never coincide
    always_ff @(posedge clka) begin
        if (ent_we) begin
            used_mem[ent_idx]  <= ent_used;
            chain_mem[ent_idx] <= '0;
            if (ent_lp_we) lpage_mem[ent_idx] <= ent_lp;
        end
        if (link_we) chain_mem[link_idx] <= link_val;
    end

    // next-state, datapath and table-write decisions
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        cache_vld_d  = cache_vld_q;
        resp_addr_d  = resp_addr_q;
        resp_page_d  = resp_page_q;
        resp_alloc_d = resp_alloc_q;
        resp_error_d = resp_error_q;
        is_tr_d      = is_tr_q;
        seg_d        = seg_q;
        cur_d        = cur_q;
        lp_d         = lp_q;
        off_d        = off_q;
        cache_seg_d  = cache_seg_q;
        cache_lp_d   = cache_lp_q;
        cache_pg_d   = cache_pg_q;
        ent_we       = 1'b0;
        ent_idx      = cnt_q;
        ent_used     = 1'b0;
        ent_lp_we    = 1'b0;
        ent_lp       = '0;
        link_we      = 1'b0;
        link_idx     = cur_q;
        link_val     = ptr_q;

        unique case (state_q)
            S_INIT: begin
                // page 0 is written as used on its own clear pass
                ent_we    = 1'b1;
                ent_idx   = cnt_q;
                ent_used  = (cnt_q == '0);
                ent_lp_we = 1'b1;
                if (cnt_q == LAST_PG) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + PG_W'(1);
                end
            end
            S_IDLE: begin
                if (req_valid) begin
                    is_tr_d      = (req_cmd == CMD_TRANSLATE);
                    seg_d        = req_seg;
                    cur_d        = req_seg;
                    lp_d         = req_lp;
                    off_d        = req_off;
                    cnt_d        = '0;
                    resp_addr_d  = '0;
                    resp_page_d  = '0;
                    resp_alloc_d = 1'b0;
                    resp_error_d = 1'b0;
                    unique case (req_cmd)
                        CMD_TRANSLATE: begin
                            if (!seg_ok) begin
                                resp_error_d = 1'b1;
                                state_d      = S_RESP;
                            end else if (req_lp == '0 || cache_hit) begin
                                resp_page_d = (req_lp == '0) ? req_seg : cache_pg_q;
                                resp_addr_d = phys_addr(resp_page_d, req_off);
                                cache_vld_d = 1'b1;
                                cache_seg_d = req_seg;
                                cache_lp_d  = req_lp;
                                cache_pg_d  = resp_page_d;
                                state_d     = S_RESP;
                            end else begin
                                state_d = S_WALK;
                            end
                        end
                        CMD_NEW_SEG: begin
                            lp_d    = '0;
                            state_d = S_SCAN;
                        end
                        CMD_FREE_SEG: begin
                            if (!seg_ok) begin
                                resp_error_d = 1'b1;
                                state_d      = S_RESP;
                            end else begin
                                state_d = S_FREE;
                            end
                        end
                        default: begin
                            resp_error_d = 1'b1;
                            state_d      = S_RESP;
                        end
                    endcase
                end
            end
            S_WALK: begin
                if (nxt_pg == '0) begin
                    state_d = S_SCAN;
                end else if (lpage_mem[nxt_pg] == lp_q) begin
                    resp_page_d = nxt_pg;
                    resp_addr_d = phys_addr(nxt_pg, off_q);
                    cache_vld_d = 1'b1;
                    cache_seg_d = seg_q;
                    cache_lp_d  = lp_q;
                    cache_pg_d  = nxt_pg;
                    state_d     = S_RESP;
                end else begin
                    cur_d = nxt_pg;
                end
            end
            S_SCAN: begin
                ptr_d = ptr_inc(ptr_q);
                if (!used_mem[ptr_q]) begin
                    ent_we       = 1'b1;
                    ent_idx      = ptr_q;
                    ent_used     = 1'b1;
                    ent_lp_we    = 1'b1;
                    ent_lp       = lp_q;
                    link_we      = is_tr_q;
                    link_idx     = cur_q;
                    link_val     = ptr_q;
                    resp_page_d  = ptr_q;
                    resp_addr_d  = is_tr_q ? phys_addr(ptr_q, off_q) : '0;
                    resp_alloc_d = is_tr_q;
                    if (is_tr_q) begin
                        cache_vld_d = 1'b1;
                        cache_seg_d = seg_q;
                        cache_lp_d  = lp_q;
                        cache_pg_d  = ptr_q;
                    end
                    state_d = S_RESP;
                end else if (cnt_q == SCAN_LAST) begin
                    // full lap without a free page; pointer is back at its start
                    resp_error_d = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    cnt_d = cnt_q + PG_W'(1);
                end
            end
            S_FREE: begin
                ent_we   = 1'b1;
                ent_idx  = cur_q;
                ent_used = 1'b0;
                if (cur_q < ptr_q) ptr_d = cur_q;
                if (nxt_pg == '0) begin
                    cache_vld_d = 1'b0;
                    resp_page_d = seg_q;
                    state_d     = S_RESP;
                end else begin
                    cur_d = nxt_pg;
                end
            end
            S_RESP: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
    end

    // interface outputs derived from state and held response registers
    always_comb begin
        req_ready  = (state_q == S_IDLE);
        resp_valid = (state_q == S_RESP);
        resp_addr  = resp_addr_q;
        resp_page  = resp_page_q;
        resp_alloc = resp_alloc_q;
        resp_error = resp_error_q;
    end

endmodule

// File: tb/tb_mmu_page_responder.sv
// Testbench for mmu_page_responder: directed scenarios with literal
// expectations, then randomized requests checked against a table-level model.
module tb_mmu_page_responder;

    localparam int PAGE_SIZE = 5;
    localparam int PAGES     = 204;
    localparam int ADDR_W    = 10;
    localparam int PG_W      = 8;

    logic              clka       = 1'b0;
    logic              rst        = 1'b1;
    logic              req_valid  = 1'b0;
    logic [1:0]        req_cmd    = '0;
    logic [PG_W-1:0]   req_seg    = '0;
    logic [ADDR_W-1:0] req_addr   = '0;
    logic              resp_ready = 1'b0;
    logic              req_ready;
    logic              resp_valid;
    logic [ADDR_W-1:0] resp_addr;
    logic [PG_W-1:0]   resp_page;
    logic              resp_alloc;
    logic              resp_error;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit m_used  [PAGES];
    int m_chain [PAGES];
    int m_lpage [PAGES];
    int m_ptr;
    bit c_vld;
    int c_seg, c_lp, c_pg;
    int segs[$];

    // expected response of the request in flight
    int e_addr, e_page, e_alloc, e_err, e_lat;
    bit cmp_on = 1'b0;

    // captured DUT response of the last request
    int got_addr, got_page, got_alloc, got_err, got_lat;

    mmu_page_responder #(
        .PAGE_SIZE(PAGE_SIZE), .PAGES(PAGES), .ADDR_W(ADDR_W), .PG_W(PG_W)
    ) dut (
        .clka       (clka),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_cmd    (req_cmd),
        .req_seg    (req_seg),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_addr  (resp_addr),
        .resp_page  (resp_page),
        .resp_alloc (resp_alloc),
        .resp_error (resp_error)
    );

    always #5 clka = ~clka;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < PAGES; p++) begin
            m_used[p]  = (p == 0);
            m_chain[p] = 0;
            m_lpage[p] = 0;
        end
        m_ptr = 1;
        c_vld = 0;
        segs.delete();
    endtask

    // search for a free page starting at the pointer; claims it when found
    task automatic model_scan(output int f, output int s);
        int p;
        f = -1;
        s = 0;
        p = m_ptr;
        for (int i = 0; i < PAGES - 1; i++) begin
            s++;
            if (!m_used[p]) begin
                f = p;
                break;
            end
            p = (p == PAGES - 1) ? 1 : p + 1;
        end
        if (f >= 0) begin
            m_used[f]  = 1;
            m_chain[f] = 0;
            m_ptr      = (f == PAGES - 1) ? 1 : f + 1;
        end
    endtask

    task automatic model_req(input int cmd, input int seg, input int addr);
        int l, off, pg, cur, k, nx, f, s;
        bit seg_ok;
        e_addr = 0; e_page = 0; e_alloc = 0; e_err = 0; e_lat = 1;
        l      = addr / PAGE_SIZE;
        off    = addr % PAGE_SIZE;
        seg_ok = (seg != 0) && (seg < PAGES) && m_used[seg];
        case (cmd)
            0: begin
                if (!seg_ok) begin
                    e_err = 1;
                end else begin
                    pg = -1;
                    if (l == 0) pg = seg;
                    else if (c_vld && c_seg == seg && c_lp == l) pg = c_pg;
                    else begin
                        cur = seg;
                        k   = 0;
                        while (k <= PAGES) begin
                            k++;
                            nx = m_chain[cur];
                            if (nx == 0) break;
                            if (m_lpage[nx] == l) begin
                                pg = nx;
                                break;
                            end
                            cur = nx;
                        end
                        e_lat = 1 + k;
                        if (pg < 0) begin
                            model_scan(f, s);
                            e_lat += s;
                            if (f < 0) e_err = 1;
                            else begin
                                m_lpage[f]   = l;
                                m_chain[cur] = f;
                                pg           = f;
                                e_alloc      = 1;
                            end
                        end
                    end
                    if (!e_err) begin
                        e_page = pg;
                        e_addr = pg * PAGE_SIZE + off;
                        c_vld = 1; c_seg = seg; c_lp = l; c_pg = pg;
                    end
                end
            end
            1: begin
                model_scan(f, s);
                e_lat = 1 + s;
                if (f < 0) e_err = 1;
                else begin
                    m_lpage[f] = 0;
                    e_page     = f;
                    segs.push_back(f);
                end
            end
            2: begin
                if (!seg_ok) begin
                    e_err = 1;
                end else begin
                    cur = seg;
                    k   = 0;
                    do begin
                        k++;
                        nx           = m_chain[cur];
                        m_used[cur]  = 0;
                        m_chain[cur] = 0;
                        if (cur < m_ptr) m_ptr = cur;
                        cur = nx;
                    end while (nx != 0 && k <= PAGES);
                    e_lat  = 1 + k;
                    c_vld  = 0;
                    e_page = seg;
                    for (int j = 0; j < segs.size(); j++) begin
                        if (segs[j] == seg) begin
                            segs.delete(j);
                            break;
                        end
                    end
                end
            end
            default: e_err = 1;
        endcase
    endtask

    // compare process: every cycle a response is presented it must match the model
    always @(negedge clka) begin
        if (cmp_on && resp_valid) begin
            check("resp_addr", int'(resp_addr), e_addr);
            check("resp_page", int'(resp_page), e_page);
            check("resp_alloc", int'(resp_alloc), e_alloc);
            check("resp_error", int'(resp_error), e_err);
            check("req_ready_in_resp", int'(req_ready), 0);
        end
    end

    task automatic wait_init();
        int n;
        n = 0;
        while (!req_ready && n < 1000) begin
            @(posedge clka); #1;
            n++;
        end
        check("init_cycles", n, PAGES);
    endtask

    task automatic do_req(input int cmd, input int seg, input int addr, input int hold);
        int n;
        @(negedge clka);
        n = 0;
        while (!req_ready && n < 500) begin
            @(negedge clka);
            n++;
        end
        check("req_ready_idle", int'(req_ready), 1);
        model_req(cmd, seg, addr);
        req_valid = 1'b1;
        req_cmd   = 2'(cmd);
        req_seg   = PG_W'(seg);
        req_addr  = ADDR_W'(addr);
        @(posedge clka); #1;
        req_valid = 1'b0;
        req_cmd   = 2'($urandom);
        req_seg   = PG_W'($urandom);
        req_addr  = ADDR_W'($urandom);
        cmp_on    = 1'b1;
        got_lat   = 1;
        while (!resp_valid && got_lat < 600) begin
            @(posedge clka); #1;
            got_lat++;
        end
        check("resp_valid_seen", int'(resp_valid), 1);
        check("latency", got_lat, e_lat);
        got_addr  = int'(resp_addr);
        got_page  = int'(resp_page);
        got_alloc = int'(resp_alloc);
        got_err   = int'(resp_error);
        repeat (hold) @(posedge clka);
        @(negedge clka);
        resp_ready = 1'b1;
        @(posedge clka); #1;
        resp_ready = 1'b0;
        cmp_on     = 1'b0;
        check("resp_valid_drop", int'(resp_valid), 0);
        check("req_ready_after", int'(req_ready), 1);
    endtask

    initial begin
        int cmd, seg, addr, r;
        int n;

        // reset state
        repeat (3) @(posedge clka);
        #1;
        check("rst_req_ready", int'(req_ready), 0);
        check("rst_resp_valid", int'(resp_valid), 0);
        check("rst_resp_addr", int'(resp_addr), 0);
        check("rst_resp_page", int'(resp_page), 0);
        check("rst_resp_alloc", int'(resp_alloc), 0);
        check("rst_resp_error", int'(resp_error), 0);
        @(negedge clka);
        rst = 1'b0;
        wait_init();
        model_reset();

        // first segment, translations, allocation and cache hit
        do_req(1, 0, 0, 0);
        check("lit_newseg_page", got_page, 1);
        check("lit_newseg_err", got_err, 0);
        do_req(0, 1, 3, 0);
        check("lit_tr3_addr", got_addr, 8);
        check("lit_tr3_page", got_page, 1);
        check("lit_tr3_alloc", got_alloc, 0);
        check("lit_tr3_lat", got_lat, 1);
        do_req(0, 1, 12, 0);
        check("lit_tr12_addr", got_addr, 12);
        check("lit_tr12_page", got_page, 2);
        check("lit_tr12_alloc", got_alloc, 1);
        do_req(0, 1, 12, 0);
        check("lit_hit_lat", got_lat, 1);
        check("lit_hit_alloc", got_alloc, 0);
        do_req(0, 1, 14, 0);
        check("lit_tr14_addr", got_addr, 14);

        // exhaust the page pool
        for (int i = 0; i < 202; i++) do_req(1, 0, 0, 0);
        check("lit_exhaust_err", got_err, 1);
        check("lit_exhaust_lat", got_lat, 1 + (PAGES - 1));
        do_req(0, 1, 20, 0);
        check("lit_tr20_err", got_err, 1);

        // free segment 1 with a held response, then reuse
        do_req(2, 1, 0, 5);
        check("lit_free_page", got_page, 1);
        check("lit_free_err", got_err, 0);
        check("lit_free_lat", got_lat, 3);
        do_req(1, 0, 0, 0);
        check("lit_realloc_page", got_page, 1);
        do_req(2, 0, 0, 0);
        check("lit_free0_err", got_err, 1);
        do_req(3, 1, 0, 0);
        check("lit_reserved_err", got_err, 1);
        do_req(0, 1, 12, 0);
        check("lit_cache_inval_alloc", got_alloc, 1);
        check("lit_cache_inval_page", got_page, 2);

        // reset while walking the chain 1 -> 2 for logical page 3
        @(negedge clka);
        n = 0;
        while (!req_ready && n < 500) begin
            @(negedge clka);
            n++;
        end
        req_valid = 1'b1;
        req_cmd   = 2'd0;
        req_seg   = PG_W'(1);
        req_addr  = ADDR_W'(15);
        @(posedge clka); #1;
        req_valid = 1'b0;
        check("walk_busy_valid", int'(resp_valid), 0);
        check("walk_busy_ready", int'(req_ready), 0);
        #2 rst = 1'b1;
        #1;
        check("midrst_resp_valid", int'(resp_valid), 0);
        check("midrst_req_ready", int'(req_ready), 0);
        @(negedge clka);
        rst = 1'b0;
        wait_init();
        model_reset();
        do_req(1, 0, 0, 0);
        check("lit_post_rst_page", got_page, 1);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            r    = $urandom_range(0, 99);
            seg  = 0;
            addr = 0;
            if (r < 45) begin
                cmd = 0;
                if (segs.size() > 0 && $urandom_range(0, 9) != 0)
                    seg = segs[$urandom_range(0, segs.size() - 1)];
                else
                    seg = $urandom_range(0, PAGES - 1);
                addr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023)
                                                    : $urandom_range(0, 24);
            end else if (r < 72) begin
                cmd = 1;
            end else if (r < 94) begin
                cmd = 2;
                if (segs.size() > 0) seg = segs[$urandom_range(0, segs.size() - 1)];
            end else begin
                cmd = 3;
                seg = $urandom_range(0, PAGES - 1);
            end
            do_req(cmd, seg, addr, $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mmu_page_responder.md
Name: mmu_page_responder

Overview:
- Memory-side responder for the CPU's MMU request interface.
- Owns the page-chain and logical-page tables and answers translation requests with a physical RAM address.
- Allocates a free physical page when a logical page is missing, and creates and frees per-process segment chains.
- Sits between the instruction/data-fetch stage and the dual-port block RAM address lines; one request is serviced at a time.

Parameters:
- PAGE_SIZE, 5, words per page.
- PAGES, 204, physical pages; PAGES*PAGE_SIZE must be <= 2^ADDR_W.
- ADDR_W, 10, logical/physical word address width.
- PG_W, 8, page index width.

Ports:
- clka  in  1  clock, all state on posedge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; accept = req_valid & req_ready.
- req_cmd  in  2  0=TRANSLATE, 1=NEW_SEG, 2=FREE_SEG, 3=reserved (answered with error).
- req_seg  in  PG_W  process segment start page (TRANSLATE, FREE_SEG).
- req_addr  in  ADDR_W  logical address (TRANSLATE).
- resp_valid  out  1  response held until resp_ready.
- resp_ready  in  1  response consumed when resp_valid & resp_ready.
- resp_addr  out  ADDR_W  physical address (TRANSLATE), else 0.
- resp_page  out  PG_W  physical page used or created.
- resp_alloc  out  1  TRANSLATE allocated a new page.
- resp_error  out  1  no free page, invalid segment, or reserved cmd.

Behaviour:
- Tables, one entry per page: used[p], chain[p] (next page, 0 = end), lpage[p] (logical page number). Also alloc_ptr, a scan start pointer, and a one-entry cache {valid, seg, lpage, page}.
- Reset:
  - All outputs 0; state INIT; cache invalid; alloc_ptr=1.
  - After rst falls, INIT clears one entry per cycle (p = 0..PAGES-1), then sets used[0]=1 (page 0 is reserved) and enters IDLE. INIT lasts PAGES cycles.
  - req_ready=0 throughout INIT.
  - rst in any state aborts the operation immediately: resp_valid=0, tables restart INIT.
- States: INIT, IDLE, WALK, SCAN, FREE, RESP.
- TRANSLATE, with L = req_addr / PAGE_SIZE and off = req_addr % PAGE_SIZE:
  - Cache hit (valid, seg and L match) or L=0: go to RESP on the accept edge; resp_valid=1 one cycle after accept.
  - Otherwise WALK with cur=req_seg, one chain step per cycle:
    - next=chain[cur]=0: go to SCAN.
    - lpage[next]=L: found, go to RESP.
    - otherwise cur<=next.
  - TRANSLATE with used[req_seg]=0 or req_seg=0: resp_error=1, no table change.
- SCAN tests used[alloc_ptr] one entry per cycle.
  - alloc_ptr wraps from PAGES-1 to 1.
  - Free entry found: used=1, chain=0, lpage=L (0 for NEW_SEG). For TRANSLATE, also chain[cur]<=found. Then alloc_ptr<=found+1 (wrapped).
  - PAGES-1 entries tested with none free: resp_error=1, no table change.
- Result address: resp_addr = page*PAGE_SIZE + off. resp_alloc=1 only if SCAN succeeded for TRANSLATE. A successful TRANSLATE loads the cache.
- NEW_SEG: goes through SCAN. Response carries resp_page = new segment start, resp_addr=0.
- FREE_SEG:
  - req_seg=0 or used[req_seg]=0: error.
  - Otherwise FREE clears one page per cycle along the chain (used=0, chain=0), setting alloc_ptr<=min(alloc_ptr, page).
  - Ends after the page with chain=0; invalidates the cache; resp_page=req_seg.
- RESP holds every resp_* stable until resp_ready, then returns to IDLE. The next request is acceptable the cycle after, because req_ready rises in IDLE.
- Back-to-back: there is no overlap of requests. req_* is sampled only at the accept edge.

Test Plan:
- Assert rst, release -> req_ready=0 for 204 cycles, then 1. NEW_SEG -> resp_page=1, resp_error=0.
- TRANSLATE seg=1 addr=3 -> resp_valid one cycle after accept, resp_addr=8, resp_page=1, resp_alloc=0.
- TRANSLATE seg=1 addr=12 -> SCAN allocates page 2, resp_addr=12, resp_alloc=1. Repeat the same request -> cache hit, latency 1, resp_addr=12, resp_alloc=0. addr=14 -> resp_addr=14.
- NEW_SEG 202 times after the first two pages -> the final request gives resp_error=1 after 203 SCAN cycles. A following TRANSLATE seg=1 addr=20 -> resp_error=1, chain[2] stays 0.
- FREE_SEG seg=1 -> pages 1 and 2 freed, alloc_ptr=1, cache invalid. NEW_SEG -> resp_page=1. FREE_SEG seg=0 -> resp_error=1.
- Hold resp_ready=0 for 5 cycles -> response fields stable, req_ready=0. Assert rst during WALK -> resp_valid=0 at once, INIT rerun, prior allocations gone (NEW_SEG -> page 1).
